// File: rtl/riscv_trace_capture.sv
// riscv_trace_capture
//   Captures retired-instruction records (PC, expanded instruction, RVC flag,
//   cycle stamp), classifies each one from its opcode/funct fields, and
//   buffers the records in a show-ahead FIFO with a valid/ready sink.
//   When the FIFO is full and the sink does not pop, the new record is
//   dropped; a sticky overflow flag and a saturating drop counter record it.
//
// Parameters:
//   DEPTH       FIFO entries (power of two, 2..64)
//   DROP_CNT_W  drop counter width
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   retire_valid_i/pc_i/instr_i/compressed_i   retirement record in
//   clear_i                            clears overflow_o and drop_cnt_o
//   trace_valid_o, trace_ready_i       sink handshake
//   trace_pc_o/instr_o/compressed_o/class_o/stamp_o   FIFO head (0 when empty)
//   fifo_count_o                       occupancy
//   overflow_o, drop_cnt_o             lossy back-pressure status
//
// Optional feature:
//   RISCV_TRACE_FPU_EN  when defined, FP opcodes classify as FP (10) and FP
//                       loads/stores as LOAD/STORE; otherwise all are UNKNOWN.

module riscv_trace_capture #(
  parameter int DEPTH      = 8,
  parameter int DROP_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     retire_valid_i,
  input  logic [31:0]              retire_pc_i,
  input  logic [31:0]              retire_instr_i,
  input  logic                     retire_compressed_i,
  input  logic                     clear_i,
  output logic                     trace_valid_o,
  input  logic                     trace_ready_i,
  output logic [31:0]              trace_pc_o,
  output logic [31:0]              trace_instr_o,
  output logic                     trace_compressed_o,
  output logic [3:0]               trace_class_o,
  output logic [31:0]              trace_stamp_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     overflow_o,
  output logic [DROP_CNT_W-1:0]    drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPCODE_LOAD    = 7'h03;
  localparam logic [6:0] OPCODE_FENCE   = 7'h0f;
  localparam logic [6:0] OPCODE_OPIMM   = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC   = 7'h17;
  localparam logic [6:0] OPCODE_STORE   = 7'h23;
  localparam logic [6:0] OPCODE_OP      = 7'h33;
  localparam logic [6:0] OPCODE_LUI     = 7'h37;
  localparam logic [6:0] OPCODE_PULP_OP = 7'h5b;
  localparam logic [6:0] OPCODE_BRANCH  = 7'h63;
  localparam logic [6:0] OPCODE_JALR    = 7'h67;
  localparam logic [6:0] OPCODE_JAL     = 7'h6f;
  localparam logic [6:0] OPCODE_SYSTEM  = 7'h73;
`ifdef RISCV_TRACE_FPU_EN
  localparam logic [6:0] OPCODE_LOAD_FP   = 7'h07;
  localparam logic [6:0] OPCODE_STORE_FP  = 7'h27;
  localparam logic [6:0] OPCODE_OP_FMADD  = 7'h43;
  localparam logic [6:0] OPCODE_OP_FMSUB  = 7'h47;
  localparam logic [6:0] OPCODE_OP_FNMSUB = 7'h4b;
  localparam logic [6:0] OPCODE_OP_FNMADD = 7'h4f;
  localparam logic [6:0] OPCODE_OP_FP     = 7'h53;
`endif

  // Classification of the incoming instruction (priority order matters:
  // MULDIV and PULP encodings share OPCODE_OP with plain ALU ops).
  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [3:0] class_in;

  assign opcode = retire_instr_i[6:0];
  assign funct7 = retire_instr_i[31:25];
  assign funct3 = retire_instr_i[14:12];

  always_comb begin
    class_in = 4'd0;
    if (opcode == OPCODE_OP && (funct7 == 7'b0000001 || funct7 == 7'b0100001))
      class_in = 4'd8;
    else if (opcode == OPCODE_PULP_OP ||
             (opcode == OPCODE_OP && (funct7 == 7'b0000010 || funct7 == 7'b0000100 ||
                                      funct7 == 7'b0001000 || funct7 == 7'b0001010 ||
                                      retire_instr_i[31])))
      class_in = 4'd9;
    else if (opcode == OPCODE_OP || opcode == OPCODE_OPIMM ||
             opcode == OPCODE_LUI || opcode == OPCODE_AUIPC)
      class_in = 4'd1;
    else if (opcode == OPCODE_BRANCH)
      class_in = 4'd2;
    else if (opcode == OPCODE_JAL || opcode == OPCODE_JALR)
      class_in = 4'd3;
    else if (opcode == OPCODE_LOAD)
      class_in = 4'd4;
    else if (opcode == OPCODE_STORE)
      class_in = 4'd5;
    else if (opcode == OPCODE_SYSTEM && funct3 != 3'b000)
      class_in = 4'd6;
    else if (opcode == OPCODE_SYSTEM || opcode == OPCODE_FENCE)
      class_in = 4'd7;
`ifdef RISCV_TRACE_FPU_EN
    else if (opcode == OPCODE_OP_FP || opcode == OPCODE_OP_FMADD ||
             opcode == OPCODE_OP_FMSUB || opcode == OPCODE_OP_FNMSUB ||
             opcode == OPCODE_OP_FNMADD)
      class_in = 4'd10;
    else if (opcode == OPCODE_LOAD_FP)
      class_in = 4'd4;
    else if (opcode == OPCODE_STORE_FP)
      class_in = 4'd5;
`endif
  end

  logic [31:0]           mem_pc    [DEPTH];
  logic [31:0]           mem_instr [DEPTH];
  logic                  mem_comp  [DEPTH];
  logic [3:0]            mem_class [DEPTH];
  logic [31:0]           mem_stamp [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [31:0]           stamp_q;
  logic                  overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = !empty && trace_ready_i;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push  = retire_valid_i && (!full || pop);
  assign drop  = retire_valid_i && full && !pop;

  // Storage has no reset: head outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= retire_pc_i;
      mem_instr[wr_ptr] <= retire_instr_i;
      mem_comp[wr_ptr]  <= retire_compressed_i;
      mem_class[wr_ptr] <= class_in;
      mem_stamp[wr_ptr] <= stamp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      stamp_q    <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      stamp_q <= stamp_q + 32'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      // A drop coinciding with clear restarts the count at one.
      if (drop) begin
        overflow_q <= 1'b1;
        if (clear_i)          drop_cnt_q <= DROP_CNT_W'(1);
        else if (!(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
      end else if (clear_i) begin
        overflow_q <= 1'b0;
        drop_cnt_q <= '0;
      end
    end
  end

  assign trace_valid_o      = !empty;
  assign trace_pc_o         = empty ? 32'd0 : mem_pc[rd_ptr];
  assign trace_instr_o      = empty ? 32'd0 : mem_instr[rd_ptr];
  assign trace_compressed_o = empty ? 1'b0  : mem_comp[rd_ptr];
  assign trace_class_o      = empty ? 4'd0  : mem_class[rd_ptr];
  assign trace_stamp_o      = empty ? 32'd0 : mem_stamp[rd_ptr];
  assign fifo_count_o       = count_q;
  assign overflow_o         = overflow_q;
  assign drop_cnt_o         = drop_cnt_q;

endmodule

// File: tb/tb_riscv_trace_capture.sv
module tb_riscv_trace_capture;

  localparam int DEPTH = 8;
  localparam int DCW   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire_valid_i = 1'b0;
  logic [31:0] retire_pc_i = '0;
  logic [31:0] retire_instr_i = '0;
  logic        retire_compressed_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        trace_valid_o;
  logic        trace_ready_i = 1'b0;
  logic [31:0] trace_pc_o;
  logic [31:0] trace_instr_o;
  logic        trace_compressed_o;
  logic [3:0]  trace_class_o;
  logic [31:0] trace_stamp_o;
  logic [$clog2(DEPTH):0] fifo_count_o;
  logic        overflow_o;
  logic [DCW-1:0] drop_cnt_o;

  int errors = 0;
  int checks = 0;

  riscv_trace_capture #(.DEPTH(DEPTH), .DROP_CNT_W(DCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .retire_valid_i(retire_valid_i), .retire_pc_i(retire_pc_i),
    .retire_instr_i(retire_instr_i), .retire_compressed_i(retire_compressed_i),
    .clear_i(clear_i),
    .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_pc_o(trace_pc_o), .trace_instr_o(trace_instr_o),
    .trace_compressed_o(trace_compressed_o), .trace_class_o(trace_class_o),
    .trace_stamp_o(trace_stamp_o), .fifo_count_o(fifo_count_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference cycle stamp: value the DUT counter holds during the current cycle.
  logic [31:0] ref_stamp = '0;
  always @(posedge clk) begin
    if (!rst_n) ref_stamp <= '0;
    else        ref_stamp <= ref_stamp + 32'd1;
  end

  function automatic logic [3:0] exp_class(input logic [31:0] i);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    op = i[6:0]; f7 = i[31:25]; f3 = i[14:12];
    case (op)
      7'h33: begin
        if (f7 == 7'h01 || f7 == 7'h21) return 4'd8;
        if (f7 == 7'h02 || f7 == 7'h04 || f7 == 7'h08 || f7 == 7'h0a || i[31]) return 4'd9;
        return 4'd1;
      end
      7'h5b: return 4'd9;
      7'h13, 7'h37, 7'h17: return 4'd1;
      7'h63: return 4'd2;
      7'h6f, 7'h67: return 4'd3;
      7'h03: return 4'd4;
      7'h23: return 4'd5;
      7'h73: return (f3 != 3'b000) ? 4'd6 : 4'd7;
      7'h0f: return 4'd7;
`ifdef RISCV_TRACE_FPU_EN
      7'h53, 7'h43, 7'h47, 7'h4b, 7'h4f: return 4'd10;
      7'h07: return 4'd4;
      7'h27: return 4'd5;
`endif
      default: return 4'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        comp;
    logic [3:0]  cls;
    logic [31:0] stamp;
  } rec_t;

  rec_t sb[$];

  // Scoreboard: at each falling edge, compare the head against the oldest
  // expected record, then apply the handshake that the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      bit do_pop;
      bit do_push;
      checks++;
      if (trace_valid_o !== (sb.size() != 0) || fifo_count_o !== ($clog2(DEPTH)+1)'(sb.size())) begin
        errors++;
        $display("FAIL sb_occupancy: valid=%0b count=%0d expected count=%0d", trace_valid_o, fifo_count_o, sb.size());
      end
      if (sb.size() != 0) begin
        checks++;
        if (trace_pc_o !== sb[0].pc || trace_instr_o !== sb[0].instr ||
            trace_compressed_o !== sb[0].comp || trace_class_o !== sb[0].cls ||
            trace_stamp_o !== sb[0].stamp) begin
          errors++;
          $display("FAIL sb_head: got pc=%h instr=%h c=%0b cls=%0d stamp=%0d expected pc=%h instr=%h c=%0b cls=%0d stamp=%0d",
                   trace_pc_o, trace_instr_o, trace_compressed_o, trace_class_o, trace_stamp_o,
                   sb[0].pc, sb[0].instr, sb[0].comp, sb[0].cls, sb[0].stamp);
        end
      end else begin
        checks++;
        if (trace_pc_o !== 32'd0 || trace_instr_o !== 32'd0 || trace_class_o !== 4'd0 ||
            trace_stamp_o !== 32'd0 || trace_compressed_o !== 1'b0) begin
          errors++;
          $display("FAIL sb_empty_head: pc=%h instr=%h cls=%0d stamp=%0d expected all zero",
                   trace_pc_o, trace_instr_o, trace_class_o, trace_stamp_o);
        end
      end
      do_pop  = (sb.size() != 0) && trace_ready_i;
      do_push = retire_valid_i && ((sb.size() < DEPTH) || do_pop);
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back('{retire_pc_i, retire_instr_i, retire_compressed_i,
                                  exp_class(retire_instr_i), ref_stamp});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    retire_valid_i = 1'b0;
    trace_ready_i  = 1'b1;
    for (int k = 0; k < 3*DEPTH && fifo_count_o != 0; k++) cyc();
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    checks++;
    if (trace_valid_o !== 1'b0 || fifo_count_o !== '0 || overflow_o !== 1'b0 ||
        drop_cnt_o !== '0 || trace_pc_o !== '0 || trace_stamp_o !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b count=%0d ovf=%0b drop=%0d pc=%h expected zeros",
               trace_valid_o, fifo_count_o, overflow_o, drop_cnt_o, trace_pc_o);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_latency();
    logic [31:0] s;
    trace_ready_i = 1'b1;
    cyc();
    retire_valid_i = 1'b1; retire_pc_i = 32'h80; retire_instr_i = 32'h00500093;
    s = ref_stamp;
    cyc();
    retire_valid_i = 1'b0;
    checks++;
    if (trace_valid_o !== 1'b1 || trace_class_o !== 4'd1 || trace_pc_o !== 32'h80 || trace_stamp_o !== s) begin
      errors++;
      $display("FAIL latency_addi: valid=%0b cls=%0d pc=%h stamp=%0d expected 1 1 00000080 %0d",
               trace_valid_o, trace_class_o, trace_pc_o, trace_stamp_o, s);
    end
    cyc();
    checks++;
    if (fifo_count_o !== '0) begin
      errors++;
      $display("FAIL latency_pop: count=%0d expected 0", fifo_count_o);
    end
  endtask

  task automatic test_classes();
    logic [31:0] ins [5] = '{32'h02208033, 32'h1420F0B3, 32'h30529073, 32'h00000073, 32'h00208463};
    logic [3:0]  cls [5] = '{4'd8, 4'd9, 4'd6, 4'd7, 4'd2};
    trace_ready_i = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      cyc();
      if (k > 0) begin
        checks++;
        if (trace_class_o !== cls[k-1] || trace_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL class_%0d: cls=%0d valid=%0b expected %0d", k-1, trace_class_o, trace_valid_o, cls[k-1]);
        end
      end
      retire_valid_i = (k < 5);
      if (k < 5) begin
        retire_pc_i = 32'h100 + 32'(4*k);
        retire_instr_i = ins[k];
      end
    end
    drain();
  endtask

  task automatic test_overflow();
    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    trace_ready_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      retire_valid_i = 1'b1;
      retire_pc_i = 32'h1000 + 32'(4*k);
      retire_instr_i = 32'h00500093;
      retire_compressed_i = k[0];
      cyc();
    end
    retire_valid_i = 1'b0; retire_compressed_i = 1'b0;
    checks++;
    if (fifo_count_o !== 4'd8 || overflow_o !== 1'b1 || drop_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL overflow_status: count=%0d ovf=%0b drop=%0d expected 8 1 2", fifo_count_o, overflow_o, drop_cnt_o);
    end
    checks++;
    if (trace_pc_o !== 32'h1000) begin
      errors++;
      $display("FAIL overflow_head: pc=%h expected 00001000", trace_pc_o);
    end
    drain();
    checks++;
    if (fifo_count_o !== '0) begin
      errors++;
      $display("FAIL overflow_drain: count=%0d expected 0", fifo_count_o);
    end
  endtask

  task automatic test_back_to_back();
    trace_ready_i = 1'b0;
    clear_i = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      retire_valid_i = 1'b1;
      retire_pc_i = 32'h2000 + 32'(4*k);
      retire_instr_i = 32'h00208463;
      cyc();
      clear_i = 1'b0;
    end
    trace_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      retire_pc_i = 32'h3000 + 32'(4*k);
      retire_instr_i = 32'h0040A103;
      cyc();
      checks++;
      if (fifo_count_o !== 4'd8 || drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin
        errors++;
        $display("FAIL full_pop_%0d: count=%0d drop=%0d ovf=%0b expected 8 0 0", k, fifo_count_o, drop_cnt_o, overflow_o);
      end
    end
    checks++;
    if (trace_pc_o !== 32'h2014) begin
      errors++;
      $display("FAIL full_pop_order: pc=%h expected 00002014", trace_pc_o);
    end
    drain();
  endtask

  task automatic test_clear();
    trace_ready_i = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      retire_valid_i = 1'b1;
      retire_pc_i = 32'h4000 + 32'(4*k);
      retire_instr_i = 32'h00112023;
      cyc();
    end
    checks++;
    if (drop_cnt_o !== 16'd2) begin
      errors++;
      $display("FAIL clear_pre: drop=%0d expected 2", drop_cnt_o);
    end
    clear_i = 1'b1;
    cyc();
    retire_valid_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd1) begin
      errors++;
      $display("FAIL clear_with_drop: ovf=%0b drop=%0d expected 1 1", overflow_o, drop_cnt_o);
    end
    cyc();
    clear_i = 1'b0;
    checks++;
    if (overflow_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
      errors++;
      $display("FAIL clear_alone: ovf=%0b drop=%0d expected 0 0", overflow_o, drop_cnt_o);
    end
    drain();
  endtask

  task automatic test_fpu();
    logic [3:0] want;
`ifdef RISCV_TRACE_FPU_EN
    want = 4'd10;
`else
    want = 4'd0;
`endif
    trace_ready_i = 1'b1;
    retire_valid_i = 1'b1; retire_pc_i = 32'h500; retire_instr_i = 32'h001070D3;
    cyc();
    retire_valid_i = 1'b0;
    checks++;
    if (trace_class_o !== want || trace_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL fpu_class: cls=%0d valid=%0b expected %0d", trace_class_o, trace_valid_o, want);
    end
    drain();
  endtask

  task automatic test_random();
    logic [6:0] ops [16] = '{7'h03, 7'h07, 7'h0f, 7'h13, 7'h17, 7'h23, 7'h27, 7'h33,
                             7'h37, 7'h43, 7'h53, 7'h5b, 7'h63, 7'h67, 7'h6f, 7'h73};
    logic [6:0] f7s [8] = '{7'h00, 7'h01, 7'h20, 7'h21, 7'h02, 7'h08, 7'h40, 7'h0a};
    for (int k = 0; k < 300; k++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(15)];
      ins[31:25] = f7s[$urandom_range(7)];
      retire_valid_i = ($urandom_range(3) != 0);
      retire_pc_i = $urandom;
      retire_instr_i = ins;
      retire_compressed_i = $urandom_range(1);
      trace_ready_i = ($urandom_range(2) == 0);
      cyc();
    end
    retire_compressed_i = 1'b0;
    drain();
  endtask

  task automatic test_async_reset();
    trace_ready_i = 1'b0;
    for (int k = 0; k < DEPTH + 3; k++) begin
      retire_valid_i = 1'b1;
      retire_pc_i = 32'h6000 + 32'(4*k);
      retire_instr_i = 32'h00500093;
      cyc();
    end
    checks++;
    if (overflow_o !== 1'b1 || fifo_count_o !== 4'd8) begin
      errors++;
      $display("FAIL async_pre: ovf=%0b count=%0d expected 1 8", overflow_o, fifo_count_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (trace_valid_o !== 1'b0 || fifo_count_o !== '0 || overflow_o !== 1'b0 || drop_cnt_o !== '0 ||
        trace_pc_o !== '0 || trace_instr_o !== '0 || trace_class_o !== '0 || trace_stamp_o !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%0b count=%0d ovf=%0b drop=%0d pc=%h expected zeros",
               trace_valid_o, fifo_count_o, overflow_o, drop_cnt_o, trace_pc_o);
    end
    retire_valid_i = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    trace_ready_i = 1'b1;
    retire_valid_i = 1'b1; retire_pc_i = 32'h7000; retire_instr_i = 32'h0000006F;
    cyc();
    retire_valid_i = 1'b0;
    checks++;
    if (trace_class_o !== 4'd3 || trace_stamp_o !== 32'd0) begin
      errors++;
      $display("FAIL async_after: cls=%0d stamp=%0d expected 3 0", trace_class_o, trace_stamp_o);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_classes();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_fpu();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/riscv_trace_capture.md
Name: riscv_trace_capture

Overview:
- Sits downstream of the core's retirement point and upstream of the simulation trace printer.
- Captures each retired instruction record (PC, raw instruction, cycle stamp) and classifies it with the RV32 and PULP opcode/funct masks from riscv_tracer_defines / riscv_defines.
- Buffers records in a show-ahead FIFO with a valid/ready sink interface.
- Keeps sticky overflow and drop-count status for lossy back-pressure.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- DROP_CNT_W, 16, width of saturating drop counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- retire_valid_i  in  1  one instruction retires this cycle
- retire_pc_i  in  32  PC of retiring instruction
- retire_instr_i  in  32  expanded (uncompressed) instruction word
- retire_compressed_i  in  1  original instruction was RVC
- clear_i  in  1  synchronous clear of overflow flag and drop counter
- trace_valid_o  out  1  FIFO head valid
- trace_ready_i  in  1  sink accepts head
- trace_pc_o  out  32  head PC
- trace_instr_o  out  32  head instruction
- trace_compressed_o  out  1  head RVC flag
- trace_class_o  out  4  head class code
- trace_stamp_o  out  32  head cycle stamp
- fifo_count_o  out  $clog2(DEPTH)+1  occupancy
- overflow_o  out  1  sticky: at least one record dropped
- drop_cnt_o  out  DROP_CNT_W  dropped records, saturating

Behaviour:
- Reset (rst_n low, async): FIFO empty; trace_valid_o=0; fifo_count_o=0; overflow_o=0; drop_cnt_o=0; stamp counter=0. All head data outputs read 0 when empty.
- Stamp counter: 32-bit free-running, increments every cycle, wraps 0xFFFFFFFF->0. A record stores the counter value of its retire cycle.
- Classification is combinational on retire_instr_i and stored in the entry. First match in this order wins:
  - 8 MULDIV: OPCODE_OP with funct7 0000001 or 0100001.
  - 9 PULP: OPCODE_PULP_OP; or OPCODE_OP with funct7 in {0000010, 0000100, 0001000, 0001010} or instr[31:30]=1x.
  - 1 ALU: remaining OPCODE_OP, OPCODE_OPIMM, OPCODE_LUI, OPCODE_AUIPC.
  - 2 BRANCH: OPCODE_BRANCH.
  - 3 JUMP: OPCODE_JAL, OPCODE_JALR.
  - 4 LOAD: OPCODE_LOAD.
  - 5 STORE: OPCODE_STORE.
  - 6 CSR: OPCODE_SYSTEM with funct3 != 000.
  - 7 SYSTEM: OPCODE_SYSTEM with funct3 = 000, and OPCODE_FENCE.
  - 10 FP: see Optional Feature.
  - 0 UNKNOWN: anything else.
- Push: retire_valid_i=1 and (not full, or pop in the same cycle).
- Pop: trace_valid_o=1 and trace_ready_i=1.
- Latency: a record pushed in cycle N is visible on the head outputs in N+1 if the FIFO was empty (registered storage, show-ahead read).
- Full + retire + pop in the same cycle: both happen; count unchanged; no drop.
- Full + retire, no pop: record dropped; overflow_o=1 from the next cycle; drop_cnt_o increments, saturating at all-ones.
- Empty + retire + ready: no bypass; the record appears next cycle.
- Pointers wrap modulo DEPTH.
- clear_i: overflow_o and drop_cnt_o go to 0 next cycle. If a drop happens in the same cycle, the drop wins: overflow_o=1, drop_cnt_o=1.
- Head outputs are stable while trace_valid_o=1 and trace_ready_i=0.

Optional Feature:
- Macro: RISCV_TRACE_FPU_EN.
- Defined: OPCODE_OP_FP, OPCODE_OP_FMADD, OPCODE_OP_FMSUB, OPCODE_OP_FNMSUB, OPCODE_OP_FNMADD classify as 10 FP. FP loads/stores (OPCODE_LOAD_FP/STORE_FP) classify as LOAD/STORE.
- Undefined: all of those opcodes classify as 0 UNKNOWN. The FP logic is absent; no other behaviour changes.

Test Plan:
- Reset, then retire addi x1,x0,5 (0x00500093) at PC 0x80 with ready=1 -> next cycle: trace_valid_o=1, trace_class_o=1, trace_pc_o=0x80, stamp = retire-cycle count; popped the following cycle, count returns to 0.
- Retire mul (0x02208033), p.clip (0x1420F0B3), csrrw (0x30529073), ecall (0x00000073), beq (0x00208463) -> classes 8, 9, 6, 7, 2 in order.
- DEPTH=8, ready=0, 10 consecutive retires -> fifo_count_o=8, overflow_o=1, drop_cnt_o=2; releasing ready returns the first 8 PCs in order.
- Full FIFO, retire and ready in the same cycle for 5 cycles -> count stays 8, drop_cnt_o unchanged, output order preserved.
- clear_i coinciding with a drop -> overflow_o=1, drop_cnt_o=1; clear_i alone -> both 0.
- fadd.s (0x001070D3) with RISCV_TRACE_FPU_EN defined -> class 10; without the macro -> class 0.
- Assert rst_n low mid-burst -> outputs return to reset values immediately, without waiting for a clock edge.
